// File: rtl/cycle_countdown_timer.sv
// Countdown timer: loads a duration on start, decrements remaining once every
// CLK_PER_TICK unpaused cycles, and pulses done for one cycle on expiry.
module cycle_countdown_timer #(
  parameter int CLK_PER_TICK = 50000000,
  parameter int DUR_W        = 32,
  parameter int PRE_W        = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DUR_W-1:0] duration,
  input  logic             pause,
  input  logic             abort,
  output logic             done,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic [DUR_W-1:0] remaining
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] prescaler_reg, prescaler_next;
  logic [DUR_W-1:0] remaining_reg, remaining_next;
  logic             tick_reg, tick_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      prescaler_reg <= '0;
      remaining_reg <= '0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
      remaining_reg <= remaining_next;
      tick_reg      <= tick_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    remaining_next = remaining_reg;
    tick_next      = 1'b0;

    if (abort) begin
      state_next     = S_IDLE;
      prescaler_next = '0;
      remaining_next = '0;
    end else if (start) begin
      // A (re)load always wins over a coincident terminal tick of the old count.
      prescaler_next = '0;
      if (duration == '0) begin
        state_next     = S_DONE;
        remaining_next = '0;
      end else begin
        state_next     = pause ? S_PAUSED : S_RUN;
        remaining_next = duration;
      end
    end else begin
      case (state_reg)
        S_RUN, S_PAUSED: begin
          if (pause) begin
            state_next = S_PAUSED;
          end else begin
            // Leaving PAUSED counts on the same edge, so pause cost is one-for-one.
            state_next = S_RUN;
            if (prescaler_reg == PRE_LAST) begin
              prescaler_next = '0;
              remaining_next = remaining_reg - DUR_ONE;
              tick_next      = 1'b1;
              if (remaining_reg == DUR_ONE) begin
                state_next = S_DONE;
              end
            end else begin
              prescaler_next = prescaler_reg + PRE_ONE;
            end
          end
        end
        S_DONE: state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign done      = (state_reg == S_DONE);
  assign busy      = (state_reg == S_RUN) || (state_reg == S_PAUSED);
  assign paused    = (state_reg == S_PAUSED);
  assign tick      = tick_reg;
  assign remaining = remaining_reg;

endmodule

// File: tb/tb_cycle_countdown_timer.sv
// Bench for cycle_countdown_timer: constant vector table, directed corner
// sequences and random stimulus checked against an elapsed-cycle model.
module tb_cycle_countdown_timer;

  localparam int P  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] duration = '0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic          done, busy, paused, tick;
  logic [DW-1:0] remaining;

  int n_checks = 0;
  int n_fail   = 0;

  cycle_countdown_timer #(
    .CLK_PER_TICK(P),
    .DUR_W       (DW),
    .PRE_W       (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .duration (duration),
    .pause    (pause),
    .abort    (abort),
    .done     (done),
    .busy     (busy),
    .paused   (paused),
    .tick     (tick),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  // Reference model: time is tracked as unpaused cycles elapsed since start.
  bit m_active, m_pause, m_done, m_tick;
  int m_dur, m_elapsed;

  task automatic model_edge(input logic r, input logic s, input logic [DW-1:0] d,
                            input logic p, input logic a);
    m_done = 1'b0;
    m_tick = 1'b0;
    if (!r || a) begin
      m_active = 1'b0; m_pause = 1'b0; m_dur = 0; m_elapsed = 0;
    end else if (s) begin
      m_elapsed = 0;
      if (d == 0) begin
        m_active = 1'b0; m_pause = 1'b0; m_dur = 0; m_done = 1'b1;
      end else begin
        m_active = 1'b1; m_pause = p; m_dur = int'(d);
      end
    end else if (m_active) begin
      m_pause = p;
      if (!p) begin
        m_elapsed++;
        if (m_elapsed % P == 0) m_tick = 1'b1;
        if (m_elapsed == m_dur * P) begin
          m_active = 1'b0; m_pause = 1'b0; m_done = 1'b1;
        end
      end
    end
  endtask

  function automatic logic [DW+3:0] model_out();
    logic [DW-1:0] rem;
    rem = m_active ? DW'(m_dur - m_elapsed / P) : '0;
    return {m_done, m_active, m_active && m_pause, m_tick, rem};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_edge(input logic r, input logic s, input logic [DW-1:0] d,
                            input logic p, input logic a);
    reset = r; start = s; duration = d; pause = p; abort = a;
    @(posedge clk);
    model_edge(r, s, d, p, a);
    @(negedge clk);
    reset = 1'b1; start = 1'b0; duration = '0; pause = 1'b0; abort = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk(tag, {done, busy, paused, tick, remaining}, model_out());
  endtask

  task automatic idle_edge();
    drive_edge(1'b1, 1'b0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic          r, s;
    logic [DW-1:0] d;
    logic          p, a;
    logic          e_done, e_busy, e_paused, e_tick;
    logic [DW-1:0] e_rem;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic [DW-1:0] d,
                              input logic p, input logic a, input logic e_done,
                              input logic e_busy, input logic e_paused,
                              input logic e_tick, input logic [DW-1:0] e_rem);
    vec_t v;
    v = '{r, s, d, p, a, e_done, e_busy, e_paused, e_tick, e_rem};
    vecs.push_back(v);
  endfunction

  initial begin
    int cnt, edge_at;
    bit seen;
    logic r, s, p, a;
    logic [DW-1:0] d;

    // Basic D=3 countdown, duration-0 start, abort behaviour in IDLE, start+pause.
    add(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0,  0, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0,  0, 1, 0, 0, 3);
    add(1, 0, 0, 0, 0,  0, 1, 0, 1, 2);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0,  0, 1, 0, 0, 2);
    add(1, 0, 0, 0, 0,  0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0,  1, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,  1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(1, 1, 4, 0, 1,  0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0);
    add(1, 1, 2, 1, 0,  0, 1, 1, 0, 2);
    add(1, 0, 0, 1, 0,  0, 1, 1, 0, 2);
    add(1, 0, 0, 0, 1,  0, 0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive_edge(vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].p, vecs[i].a);
      $display("vec %0d: r=%0b s=%0b d=%0d p=%0b a=%0b -> done=%0b busy=%0b paused=%0b tick=%0b rem=%0d",
               i, vecs[i].r, vecs[i].s, vecs[i].d, vecs[i].p, vecs[i].a,
               done, busy, paused, tick, remaining);
      chk($sformatf("vec%0d", i), {done, busy, paused, tick, remaining},
          {vecs[i].e_done, vecs[i].e_busy, vecs[i].e_paused, vecs[i].e_tick, vecs[i].e_rem});
    end

    // Pause for 10 edges starting at edge +6: done moves from +12 to +22.
    drive_edge(1, 1, 3, 0, 0);
    check_model("pause_start");
    cnt = 0; edge_at = -1;
    for (int e = 1; e <= 24; e++) begin
      drive_edge(1, 0, 0, (e >= 6 && e <= 15), 0);
      check_model($sformatf("pause_e%0d", e));
      if (paused) cnt++;
      if (done && edge_at < 0) edge_at = e;
    end
    $display("pause seq: paused cycles=%0d done after edge %0d", cnt, edge_at);
    chk("pause_cycles", cnt, 10);
    chk("pause_done_edge", edge_at, 22);

    // Abort while remaining=2, then confirm done never follows.
    drive_edge(1, 1, 5, 0, 0);
    for (int e = 1; e <= 13; e++) idle_edge();
    chk("abort_pre_rem", remaining, 2);
    drive_edge(1, 0, 0, 0, 1);
    chk("abort_out", {done, busy, paused, tick, remaining}, '0);
    seen = 1'b0;
    for (int e = 0; e < 25; e++) begin
      idle_edge();
      if (done || busy || tick) seen = 1'b1;
    end
    $display("abort seq: activity after abort=%0b", seen);
    chk("abort_quiet", seen, 0);

    // Retrigger on the edge the first count would expire.
    drive_edge(1, 1, 2, 0, 0);
    for (int e = 1; e <= 7; e++) idle_edge();
    drive_edge(1, 1, 5, 0, 0);
    chk("retrig_out", {done, busy, paused, tick, remaining}, {1'b0, 1'b1, 1'b0, 1'b0, 8'd5});
    edge_at = -1;
    for (int e = 1; e <= 22; e++) begin
      idle_edge();
      check_model($sformatf("retrig_e%0d", e));
      if (done && edge_at < 0) edge_at = e;
    end
    $display("retrigger seq: done after %0d edges", edge_at);
    chk("retrig_done_edge", edge_at, 20);

    // Single-edge reset mid-run with remaining=4.
    drive_edge(1, 1, 5, 0, 0);
    for (int e = 1; e <= 5; e++) idle_edge();
    chk("rst_pre_rem", remaining, 4);
    drive_edge(0, 0, 0, 0, 0);
    $display("reset seq: busy=%0b rem=%0d", busy, remaining);
    chk("rst_out", {done, busy, paused, tick, remaining}, '0);

    // Reset pulse between edges must not be seen.
    drive_edge(1, 1, 3, 0, 0);
    idle_edge();
    reset = 1'b0; #2; reset = 1'b1;
    idle_edge();
    check_model("glitch_model");
    chk("glitch_busy_rem", {busy, remaining}, {1'b1, 8'd3});

    // Start during the DONE cycle reloads; done still lasts one cycle.
    drive_edge(1, 1, 1, 0, 0);
    for (int e = 1; e <= 4; e++) idle_edge();
    chk("done_seen", done, 1);
    drive_edge(1, 1, 2, 0, 0);
    check_model("done_restart");
    chk("done_restart_out", {done, busy, remaining}, {1'b0, 1'b1, 8'd2});
    drive_edge(1, 0, 0, 0, 1);

    // Full-width duration counts all the way down without wrapping.
    drive_edge(1, 1, 8'hFF, 0, 0);
    edge_at = -1;
    for (int e = 1; e <= 255 * P + 2; e++) begin
      idle_edge();
      check_model($sformatf("max_e%0d", e));
      if (done && edge_at < 0) edge_at = e;
    end
    $display("max duration seq: done after %0d edges", edge_at);
    chk("max_done_edge", edge_at, 255 * P);

    // Random traffic against the model.
    p = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 24) == 0);
      d = ($urandom_range(0, 7) == 0) ? 8'd0 : DW'($urandom_range(1, 6));
      a = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 9) == 0) p = ~p;
      drive_edge(r, s, d, p, a);
      check_model($sformatf("rand_c%0d", c));
    end
    $display("random seq: 3000 cycles applied");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
